// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation codes, alu_op classes and forwarding selects.
package pipe_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_SLT = 4'b1111;

    localparam logic [1:0] ALU_OP_MEM    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    typedef enum logic [1:0] {
        FwdRegfile = 2'b00,
        FwdExmem   = 2'b01,
        FwdMemwb   = 2'b10
    } fwd_sel_e;

    // EX/MEM has priority over MEM/WB; x0 is never forwarded.
    function automatic fwd_sel_e fwd_select(input logic [4:0] idx,
                                            input logic [4:0] exmem_rd,
                                            input logic       exmem_we,
                                            input logic [4:0] memwb_rd,
                                            input logic       memwb_we);
        if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == idx)) return FwdExmem;
        if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == idx)) return FwdMemwb;
        return FwdRegfile;
    endfunction

endpackage

// File: rtl/alu_control.sv
// Combinational ALU-control decode: alu_op class, funct3 and funct7[5] to 4-bit ALU operation.
module alu_control
    import pipe_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] operation
);

    always_comb begin
        operation = ALU_ADD;
        case (alu_op)
            ALU_OP_MEM:    operation = ALU_ADD;
            ALU_OP_BRANCH: operation = ALU_SUB;
            default: begin
                case (funct3)
                    // Only R-type distinguishes SUB; ADDI has no funct7 field.
                    3'b000:  operation = (alu_op == ALU_OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  operation = ALU_SLL;
                    3'b010:  operation = ALU_SLT;
                    3'b011:  operation = ALU_SLT;
                    3'b100:  operation = ALU_XOR;
                    3'b101:  operation = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  operation = ALU_OR;
                    default: operation = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode and EX operand forwarding.
// Forwarding muxes are built only when ID_EX_FORWARDING_EN is defined.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic [1:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [2:0]      ex_funct3,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_operand1,
    output logic [XLEN-1:0] ex_operand2,
    output logic [3:0]      ex_operation,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch
);

    logic [3:0]      id_operation;
    logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]      rs1_q, rs2_q;
    logic            alu_src_q;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd, operand2_pre;

    alu_control u_alu_control (
        .alu_op    (id_alu_op),
        .funct3    (id_funct3),
        .funct7_5  (id_funct7_5),
        .operation (id_operation)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_funct3     <= '0;
            ex_rd         <= '0;
            ex_operation  <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            alu_src_q     <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (flush) begin
            // Bubble: kill valid and side-effecting controls, leave data alone.
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_pc         <= id_pc;
            ex_funct3     <= id_funct3;
            ex_rd         <= id_rd;
            ex_operation  <= id_operation;
            rs1_data_q    <= id_rs1_data;
            rs2_data_q    <= id_rs2_data;
            imm_q         <= id_imm;
            rs1_q         <= id_rs1;
            rs2_q         <= id_rs2;
            alu_src_q     <= id_alu_src;
            ex_reg_write  <= id_reg_write  & id_valid;
            ex_mem_read   <= id_mem_read   & id_valid;
            ex_mem_write  <= id_mem_write  & id_valid;
            ex_mem_to_reg <= id_mem_to_reg & id_valid;
            ex_branch     <= id_branch     & id_valid;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    fwd_sel_e sel1, sel2;

    always_comb begin
        sel1 = fwd_select(rs1_q, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
        sel2 = fwd_select(rs2_q, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
        unique case (sel1)
            FwdExmem: rs1_fwd = exmem_result;
            FwdMemwb: rs1_fwd = memwb_result;
            default:  rs1_fwd = rs1_data_q;
        endcase
        unique case (sel2)
            FwdExmem: rs2_fwd = exmem_result;
            FwdMemwb: rs2_fwd = memwb_result;
            default:  rs2_fwd = rs2_data_q;
        endcase
    end
`else
    logic unused_fwd;

    assign rs1_fwd    = rs1_data_q;
    assign rs2_fwd    = rs2_data_q;
    assign unused_fwd = ^{exmem_rd, exmem_reg_write, exmem_result, memwb_rd,
                          memwb_reg_write, memwb_result, rs1_q, rs2_q};
`endif

    assign operand2_pre  = alu_src_q ? imm_q : rs2_fwd;
    assign ex_operand1   = rs1_fwd;
    assign ex_store_data = rs2_fwd;

    // Shift amounts use only the low five bits (drops imm[10] of SRAI).
    always_comb begin
        ex_operand2 = operand2_pre;
        if (ex_operation == ALU_SLL || ex_operation == ALU_SRL || ex_operation == ALU_SRA) begin
            ex_operand2 = {{(XLEN-5){1'b0}}, operand2_pre[4:0]};
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model checked every cycle plus directed literal checks.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7_5;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_operand1, ex_operand2, ex_store_data;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_operation;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7_5(id_funct7_5), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_operation(ex_operation),
        .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode written from the instruction's meaning: mnemonic first, then its code.
    function automatic logic [3:0] model_decode(input logic [1:0] aop, input logic [2:0] f3,
                                                input logic f7);
        string m;
        if (aop == 2'b00) m = "add";
        else if (aop == 2'b01) m = "sub";
        else begin
            case (f3)
                3'd0: m = (aop == 2'b10 && f7) ? "sub" : "add";
                3'd1: m = "sll";
                3'd2, 3'd3: m = "slt";
                3'd4: m = "xor";
                3'd5: m = f7 ? "sra" : "srl";
                3'd6: m = "or";
                default: m = "and";
            endcase
        end
        case (m)
            "and": return 4'b0000;
            "or":  return 4'b0001;
            "add": return 4'b0010;
            "sub": return 4'b0110;
            "sll": return 4'b0111;
            "srl": return 4'b1000;
            "sra": return 4'b1001;
            "xor": return 4'b1010;
            default: return 4'b1111;
        endcase
    endfunction

    // Model of the instruction currently sitting in EX.
    logic        m_valid, m_src;
    logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd, m_ctl;
    logic [2:0]  m_f3;
    logic [3:0]  m_op;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_src <= 0; m_pc <= 0; m_rs1d <= 0; m_rs2d <= 0; m_imm <= 0;
            m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_ctl <= 0; m_f3 <= 0; m_op <= 0;
        end else if (flush) begin
            m_valid <= 0;
            m_ctl <= 0;
        end else if (!stall) begin
            m_valid <= id_valid; m_src <= id_alu_src; m_pc <= id_pc;
            m_rs1d <= id_rs1_data; m_rs2d <= id_rs2_data; m_imm <= id_imm;
            m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd; m_f3 <= id_funct3;
            m_op <= model_decode(id_alu_op, id_funct3, id_funct7_5);
            m_ctl <= id_valid ? {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
                                 id_branch} : 5'b0;
        end
    end

    function automatic logic [31:0] model_fwd(input logic [4:0] idx, input logic [31:0] rf);
`ifdef ID_EX_FORWARDING_EN
        if (idx != 0 && exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (idx != 0 && memwb_reg_write && memwb_rd == idx) return memwb_result;
`endif
        return rf;
    endfunction

    always @(negedge clk) begin
        logic [31:0] e1, e2, es;
        e1 = model_fwd(m_rs1, m_rs1d);
        es = model_fwd(m_rs2, m_rs2d);
        e2 = m_src ? m_imm : es;
        if (m_op inside {4'b0111, 4'b1000, 4'b1001}) e2 = e2 % 32;
        check("cyc_valid", {31'b0, ex_valid}, {31'b0, m_valid});
        check("cyc_pc", ex_pc, m_pc);
        check("cyc_funct3", {29'b0, ex_funct3}, {29'b0, m_f3});
        check("cyc_rd", {27'b0, ex_rd}, {27'b0, m_rd});
        check("cyc_operation", {28'b0, ex_operation}, {28'b0, m_op});
        check("cyc_operand1", ex_operand1, e1);
        check("cyc_operand2", ex_operand2, e2);
        check("cyc_store_data", ex_store_data, es);
        check("cyc_ctl", {27'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                          ex_branch}, {27'b0, m_ctl});
    end

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [4:0] rd, input logic [2:0] f3,
                         input logic f7, input logic [1:0] aop, input logic src,
                         input logic [4:0] ctl);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2;
        id_rs2_data = d2; id_imm = imm; id_rd = rd; id_funct3 = f3; id_funct7_5 = f7;
        id_alu_op = aop; id_alu_src = src;
        {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = ctl;
    endtask

    task automatic fwd(input logic [4:0] erd, input logic ewe, input logic [31:0] eres,
                       input logic [4:0] mrd, input logic mwe, input logic [31:0] mres);
        exmem_rd = erd; exmem_reg_write = ewe; exmem_result = eres;
        memwb_rd = mrd; memwb_reg_write = mwe; memwb_result = mres;
    endtask

    // Indexed by {funct3, funct7_5}.
    logic [3:0] r_tab [16] = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b1111, 4'b1111,
                               4'b1111, 4'b1111, 4'b1010, 4'b1010, 4'b1000, 4'b1001,
                               4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic [3:0] i_tab [16] = '{4'b0010, 4'b0010, 4'b0111, 4'b0111, 4'b1111, 4'b1111,
                               4'b1111, 4'b1111, 4'b1010, 4'b1010, 4'b1000, 4'b1001,
                               4'b0001, 4'b0001, 4'b0000, 4'b0000};

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        fwd(0, 0, 0, 0, 0, 0);
        // add x3,x1,x2 presented during reset
        instr(1, 32'h40, 1, 5, 2, 7, 0, 3, 3'd0, 0, 2'b10, 0, 5'b10000);
        cyc(); cyc();
        check("rst_valid", {31'b0, ex_valid}, 0);
        check("rst_operation", {28'b0, ex_operation}, 0);
        check("rst_reg_write", {31'b0, ex_reg_write}, 0);
        check("rst_operand1", ex_operand1, 0);
        rst_n = 1;
        cyc();
        check("add_operation", {28'b0, ex_operation}, 32'h2);
        check("add_operand1", ex_operand1, 5);
        check("add_operand2", ex_operand2, 7);
        check("add_reg_write", {31'b0, ex_reg_write}, 1);

        for (int i = 0; i < 16; i++) begin
            instr(1, 32'h100 + i, 1, 32'h55, 2, 32'h66, 32'h3, 4, i[3:1], i[0], 2'b10, 0,
                  5'b10000);
            cyc();
            check("dec_r", {28'b0, ex_operation}, {28'b0, r_tab[i]});
            instr(1, 32'h200 + i, 1, 32'h55, 2, 32'h66, 32'h3, 4, i[3:1], i[0], 2'b11, 1,
                  5'b10000);
            cyc();
            check("dec_i", {28'b0, ex_operation}, {28'b0, i_tab[i]});
        end
        instr(1, 32'h300, 1, 10, 2, 4, 0, 0, 3'd7, 1, 2'b00, 0, 5'b01010);
        cyc();
        check("dec_mem", {28'b0, ex_operation}, 32'h2);
        instr(1, 32'h304, 1, 10, 2, 4, 0, 0, 3'd7, 1, 2'b01, 0, 5'b00001);
        cyc();
        check("dec_branch", {28'b0, ex_operation}, 32'h6);
        // srai with imm 0x405
        instr(1, 32'h308, 1, 32'h80000000, 0, 0, 32'h405, 6, 3'd5, 1, 2'b11, 1, 5'b10000);
        cyc();
        check("srai_operation", {28'b0, ex_operation}, 32'h9);
        check("srai_operand2", ex_operand2, 5);

        instr(1, 32'h400, 3, 32'h11, 4, 32'h22, 0, 8, 3'd0, 0, 2'b10, 0, 5'b10000);
        fwd(3, 1, 32'hAAAA, 3, 1, 32'hBBBB);
        cyc();
`ifdef ID_EX_FORWARDING_EN
        check("fwd_both", ex_operand1, 32'hAAAA);
`else
        check("fwd_both", ex_operand1, 32'h11);
`endif
        stall = 1;
        fwd(3, 0, 32'hAAAA, 3, 1, 32'hBBBB);
        #1;
`ifdef ID_EX_FORWARDING_EN
        check("fwd_memwb", ex_operand1, 32'hBBBB);
`else
        check("fwd_memwb", ex_operand1, 32'h11);
`endif
        fwd(0, 1, 32'hAAAA, 0, 1, 32'hBBBB);
        cyc();
        check("fwd_rd0", ex_operand1, 32'h11);
        stall = 0;

        // sw with rs2 produced by the instruction in MEM
        instr(1, 32'h500, 1, 32'h1000, 5, 32'h1234, 8, 0, 3'd2, 0, 2'b00, 1, 5'b00100);
        fwd(5, 1, 32'hDEADBEEF, 0, 0, 0);
        cyc();
        check("sw_operand2", ex_operand2, 8);
`ifdef ID_EX_FORWARDING_EN
        check("sw_store_data", ex_store_data, 32'hDEADBEEF);
`else
        check("sw_store_data", ex_store_data, 32'h1234);
`endif
        check("sw_mem_write", {31'b0, ex_mem_write}, 1);
        fwd(0, 0, 0, 0, 0, 0);

        instr(1, 32'h600, 1, 1, 2, 2, 0, 9, 3'd0, 0, 2'b10, 0, 5'b10000);
        cyc();
        stall = 1;
        instr(1, 32'h700, 1, 3, 2, 4, 0, 10, 3'd4, 0, 2'b10, 0, 5'b10000);
        cyc();
        check("stall1_pc", ex_pc, 32'h600);
        cyc();
        check("stall2_pc", ex_pc, 32'h600);
        check("stall2_valid", {31'b0, ex_valid}, 1);
        flush = 1;
        cyc();
        check("flush_valid", {31'b0, ex_valid}, 0);
        check("flush_reg_write", {31'b0, ex_reg_write}, 0);
        check("flush_pc_hold", ex_pc, 32'h600);
        stall = 0; flush = 0;
        id_valid = 0;
        cyc();
        check("nop_valid", {31'b0, ex_valid}, 0);
        check("nop_reg_write", {31'b0, ex_reg_write}, 0);
        check("nop_pc", ex_pc, 32'h700);

        instr(1, 32'h800, 1, 9, 2, 9, 0, 11, 3'd0, 1, 2'b10, 0, 5'b10000);
        cyc();
        stall = 1;
        #1 rst_n = 0;
        #1;
        check("rst_mid_valid", {31'b0, ex_valid}, 0);
        check("rst_mid_operation", {28'b0, ex_operation}, 0);
        check("rst_mid_pc", ex_pc, 0);
        stall = 0;
        cyc();
        rst_n = 1;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
